// File: rtl/sev_seg_scan.sv
// Two-digit seven-segment scan timer: synchronises the two switch nibbles and
// time-multiplexes the digit enables with a dark interval before each digit.
module sev_seg_scan #(
    parameter int REFRESH_CNT = 24000,
    parameter int BLANK_CNT   = 480,
    parameter int CNT_W       = $clog2(REFRESH_CNT) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] onboard_sw,
    input  logic [3:0] bboard_sw,
    output logic       seg1sel,
    output logic       seg2sel,
    output logic [3:0] sw,
    output logic       frame_tick
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLANK1 = 3'd1,
        SHOW1  = 3'd2,
        BLANK2 = 3'd3,
        SHOW2  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       onboard_s1_q, onboard_s2_q;
    logic [3:0]       bboard_s1_q, bboard_s2_q;
    logic [3:0]       sw_q, sw_d;
    logic             seg1sel_q, seg2sel_q, frame_tick_q;
    logic             frame_tick_d;
    logic [CNT_W-1:0] limit;
    logic             at_last;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sw_d         = sw_q;
        frame_tick_d = 1'b0;
        limit        = (state_q == BLANK1 || state_q == BLANK2) ? BLANK_LAST : REFRESH_LAST;
        at_last      = (cnt_q == limit);

        // The nibble is captured throughout the dark interval so it is frozen while lit.
        if (state_q == BLANK1) begin
            sw_d = onboard_s2_q;
        end else if (state_q == BLANK2) begin
            sw_d = bboard_s2_q;
        end

        if (state_q == IDLE) begin
            if (enable) begin
                state_d = BLANK1;
                cnt_d   = '0;
            end
        end else if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (at_last) begin
            cnt_d = '0;
            case (state_q)
                BLANK1:  state_d = SHOW1;
                SHOW1:   state_d = BLANK2;
                BLANK2:  state_d = SHOW2;
                SHOW2: begin
                    state_d      = BLANK1;
                    frame_tick_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Digit enables are decoded from the next state so they are registered and glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BLANK1;
            cnt_q        <= '0;
            onboard_s1_q <= 4'h0;
            onboard_s2_q <= 4'h0;
            bboard_s1_q  <= 4'h0;
            bboard_s2_q  <= 4'h0;
            sw_q         <= 4'h0;
            seg1sel_q    <= 1'b0;
            seg2sel_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            onboard_s1_q <= onboard_sw;
            onboard_s2_q <= onboard_s1_q;
            bboard_s1_q  <= bboard_sw;
            bboard_s2_q  <= bboard_s1_q;
            sw_q         <= sw_d;
            seg1sel_q    <= (state_d == SHOW1);
            seg2sel_q    <= (state_d == SHOW2);
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg1sel    = seg1sel_q;
    assign seg2sel    = seg2sel_q;
    assign sw         = sw_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed + random bench for sev_seg_scan with REFRESH_CNT=8, BLANK_CNT=2;
// expected outputs come from a frame-position model queued per clock edge.
module tb_sev_seg_scan;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = 2 * (B + R);

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] onboard_sw;
    logic [3:0] bboard_sw;
    logic       seg1sel, seg2sel, frame_tick;
    logic [3:0] sw;

    sev_seg_scan #(.REFRESH_CNT(R), .BLANK_CNT(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .onboard_sw (onboard_sw),
        .bboard_sw  (bboard_sw),
        .seg1sel    (seg1sel),
        .seg2sel    (seg2sel),
        .sw         (sw),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s1;
        logic       s2;
        logic [3:0] sw;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pos = edges since the scan (re)started in BLANK1 with cnt 0.
    int         pos;
    bit         idle;
    logic [3:0] sw_m, ob_s1, ob_s2, bb_s1, bb_s2;
    logic       s1_m, s2_m, tick_m;

    bit inv_on   = 0;
    bit prev_lit = 0;
    int dark_run = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; idle = 0; sw_m = 4'h0;
        ob_s1 = 4'h0; ob_s2 = 4'h0; bb_s1 = 4'h0; bb_s2 = 4'h0;
        s1_m = 0; s2_m = 0; tick_m = 0;
    endtask

    task automatic step();
        exp_t e;
        int   n, m;
        bit   lit;
        if (idle) begin
            if (enable) begin
                idle = 0;
                pos  = 0;
            end
            s1_m = 0; s2_m = 0; tick_m = 0;
        end else begin
            n = pos + 1;
            m = n % FRAME;
            if (m >= 1 && m <= B) sw_m = ob_s2;
            else if (m >= B + R + 1 && m <= 2 * B + R) sw_m = bb_s2;
            if (!enable) begin
                idle = 1;
                s1_m = 0; s2_m = 0; tick_m = 0;
            end else begin
                pos    = n;
                s1_m   = (m >= B && m <= B + R - 1);
                s2_m   = (m >= 2 * B + R && m <= FRAME - 1);
                tick_m = (m == 0);
            end
        end
        ob_s2 = ob_s1; ob_s1 = onboard_sw;
        bb_s2 = bb_s1; bb_s1 = bboard_sw;
        e = '{s1: s1_m, s2: s2_m, sw: sw_m, tick: tick_m};
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("seg1sel", seg1sel, e.s1);
        chk("seg2sel", seg2sel, e.s2);
        chk("sw", sw, e.sw);
        chk("frame_tick", frame_tick, e.tick);
        chk("sel_exclusive", seg1sel & seg2sel, 0);
        if (inv_on) begin
            lit = seg1sel | seg2sel;
            if (lit && !prev_lit && dark_run >= 0) chk("dark_run", dark_run, B);
            if (lit) dark_run = 0;
            else if (dark_run >= 0) dark_run++;
            prev_lit = lit;
        end
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        onboard_sw = 4'hA;
        bboard_sw = 4'h5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg1sel", seg1sel, 0);
        chk("rst_seg2sel", seg2sel, 0);
        chk("rst_sw", sw, 0);
        chk("rst_frame_tick", frame_tick, 0);
        reset = 1'b1;

        // Timing, tick and static nibble routing across three frames.
        repeat (50) step();
        onboard_sw = 4'h3;
        repeat (15) step();
        // Now mid-SHOW1 showing 4'h3; change it and expect 4'hC only next frame.
        chk("mid_show_sw", sw, 4'h3);
        onboard_sw = 4'hC;
        repeat (35) step();

        // Drop enable during SHOW2, idle a while, then restart.
        repeat (15) step();
        chk("pre_disable_seg2", seg2sel, 1);
        enable = 1'b0;
        repeat (6) step();
        enable = 1'b1;
        repeat (25) step();

        // Async reset mid-SHOW1, between edges.
        repeat (5) step();
        chk("pre_reset_seg1", seg1sel, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_seg1sel", seg1sel, 0);
        chk("async_sw", sw, 0);
        chk("async_frame_tick", frame_tick, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_seg1sel", seg1sel, 0);
        reset = 1'b1;
        repeat (45) step();

        // Random switch inputs with exclusivity and dark-interval invariants.
        inv_on = 1;
        for (int i = 0; i < 1000; i++) begin
            onboard_sw = 4'($urandom_range(15, 0));
            bboard_sw  = 4'($urandom_range(15, 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
- Timing front end for the dual seven-segment display.
- Synchronises the onboard and breadboard DIP-switch nibbles into `clk`.
- Time-multiplexes the two digits at a fixed refresh rate, with a blanking interval before each digit is enabled to remove ghosting.
- Outputs the selected nibble `sw` plus one-hot digit enables `seg1sel`/`seg2sel`. These feed the downstream hex-to-segment decoder and the digit drive transistors.

Parameters:
- `REFRESH_CNT`, 24000, clk cycles each digit is lit (48 MHz HSOSC gives 500 us per digit, 1 kHz frame). Must be ≥1.
- `BLANK_CNT`, 480, clk cycles both digits are dark before each digit is lit (10 us). Must be ≥1.
- `CNT_W`, `$clog2(REFRESH_CNT)+1`, width of the shared phase counter. Must hold max(REFRESH_CNT, BLANK_CNT)-1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low blanks the display.
- `onboard_sw`  in  4  digit-1 nibble, asynchronous.
- `bboard_sw`  in  4  digit-2 nibble, asynchronous.
- `seg1sel`  out  1  digit-1 enable, active high.
- `seg2sel`  out  1  digit-2 enable, active high.
- `sw`  out  4  nibble for the currently selected or about-to-be-selected digit, to the decoder.
- `frame_tick`  out  1  one-cycle pulse at the end of each complete frame.

Behaviour:
- Clock and reset:
  - One clock domain. `reset` is asynchronous and active-low.
  - While `reset`=0, all flops clear immediately, independent of `clk`.
- Reset values:
  - state=BLANK1, cnt=0.
  - `seg1sel`=0, `seg2sel`=0, `sw`=4'h0, `frame_tick`=0.
  - Synchroniser flops = 0.
- Synchronisers:
  - Each 4-bit input passes through 2 flops: `*_s1`, then `*_s2`.
  - An input stable before edge k is visible at `*_s2` after edge k+1.
- States: IDLE, BLANK1, SHOW1, BLANK2, SHOW2.
- Per-edge counter rule in the BLANK/SHOW states:
  - If cnt==LIMIT-1: go to the next state and set cnt=0.
  - Otherwise: cnt++.
  - LIMIT = `BLANK_CNT` in BLANK states, `REFRESH_CNT` in SHOW states.
- Sequence: BLANK1 → SHOW1 → BLANK2 → SHOW2 → BLANK1 …
- Frame timing:
  - Frame period = 2*(BLANK_CNT+REFRESH_CNT) cycles.
  - Dark fraction = BLANK_CNT/(BLANK_CNT+REFRESH_CNT).
- Digit enables (registered Moore outputs, glitch-free):
  - `seg1sel`=1 iff state==SHOW1.
  - `seg2sel`=1 iff state==SHOW2.
  - The two are never high together. Both are low in BLANK and IDLE.
- Nibble tracking:
  - On every edge in BLANK1, `sw` ← `onboard_sw_s2`.
  - On every edge in BLANK2, `sw` ← `bboard_sw_s2`.
  - In SHOW1/SHOW2/IDLE, `sw` holds, so the nibble is frozen for the whole lit interval.
  - An input change is displayed from the next SHOW of that digit, provided it reaches `*_s2` by the last BLANK edge. Otherwise it is displayed one frame later.
- `frame_tick`:
  - Registered. High for exactly the one cycle following the SHOW2→BLANK1 transition edge.
  - Low in all other cycles, including after reset.
- Enable:
  - `enable`=0 on any edge in a BLANK or SHOW state → IDLE, cnt=0, no `frame_tick`. `seg*sel` deassert on that same edge, because the outputs are decoded from the next state.
  - In IDLE with `enable`=0: stay.
  - In IDLE with `enable`=1: → BLANK1, cnt=0. The scan always restarts at digit 1.
  - `enable` is a synchronous input; the driver guarantees it is in the clk domain.
- Reset mid-scan: outputs drop to their reset values asynchronously. After release, the scan restarts from BLANK1 with cnt=0 (if `enable`=1).
- Width rules:
  - cnt is unsigned `CNT_W` bits.
  - Terminal compares are against the parameter minus 1, zero-extended.
  - No wrap-through; cnt never exceeds LIMIT-1.

Test Plan:
- Timing and tick:
  - Stimulus: `REFRESH_CNT`=8, `BLANK_CNT`=2, `enable`=1, release reset, count edges from the first post-release edge as 1.
  - Required: `seg1sel` high after edge 2 through edge 10; `seg2sel` high after edge 12 through edge 20; `frame_tick` high only between edges 20 and 21; pattern repeats every 20 cycles.
- Nibble routing:
  - Stimulus: `onboard_sw`=4'hA, `bboard_sw`=4'h5, held static.
  - Required: `sw`=4'hA whenever `seg1sel`=1; `sw`=4'h5 whenever `seg2sel`=1; `sw` never changes while either sel is high.
- Mid-show change:
  - Stimulus: change `onboard_sw` 4'h3→4'hC during SHOW1.
  - Required: `sw` stays 4'h3 until SHOW1 ends; 4'hC is shown in the next SHOW1; `seg2sel` intervals are unaffected.
- Enable control:
  - Stimulus: drop `enable` during SHOW2.
  - Required: `seg2sel`=0 on the next edge; no `frame_tick`; outputs idle.
  - Stimulus: re-raise `enable`.
  - Required: `seg1sel` rises exactly 2 edges after IDLE is left (BLANK1 of length 2).
- Async reset:
  - Stimulus: assert `reset`=0 asynchronously mid-SHOW1, between clock edges.
  - Required: `seg1sel`, `sw`, `frame_tick` go to 0 before the next edge; after release, the timing matches the first scenario exactly.
- Invariant check: over 1000 cycles with random switch inputs, `seg1sel`&`seg2sel` is never 1, and every lit interval is preceded by exactly `BLANK_CNT` dark cycles.
